v_dpu_seq_ctrl: RTL
===================

Name: v_dpu_seq_ctrl

Overview:
- Per-instruction sequencer for the vector DPU output path.
- Accepts an instruction descriptor (vl, reduction flag) and drives the lane valid-mask generator's load / shift_en / shift_partial controls.
- Streams ceil(vl/VLANE_NUM) result beats under downstream back-pressure. For reductions, it then shifts out VLANE_NUM-1 partial-result slots.
- Sits between the DPU issue stage and the result writeback interface.

Parameters:
- MAX_VL_PER_LANE, 256, max elements per lane.
- VLANE_NUM, 8, number of lanes; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_valid_i  in  1  descriptor valid.
- start_ready_o  out  1  controller can accept a descriptor.
- vl_i  in  $clog2(VLANE_NUM*MAX_VL_PER_LANE)  vector length of the descriptor.
- reduction_i  in  1  descriptor is a reduction (needs the partial phase).
- out_ready_i  in  1  downstream accepts a beat this cycle.
- vl_o  out  same width as vl_i  registered vl, held stable for the whole instruction.
- load_o  out  1  one-cycle load pulse to the mask generator.
- shift_en_o  out  1  result beat transferred this cycle.
- shift_partial_o  out  1  partial-result slot transferred this cycle.
- busy_o  out  1  instruction in flight.
- done_o  out  1  one-cycle pulse when the instruction completes.

Behaviour:
- Reset (async assert, applied immediately, removed synchronously):
  - state=IDLE; all counters 0; vl_o=0; is_red=0.
  - load_o, shift_en_o, shift_partial_o, done_o, busy_o all 0; start_ready_o=1.
- State IDLE:
  - start_ready_o=1.
  - On start_valid_i: capture vl_i -> vl_o, capture reduction_i -> is_red.
  - Capture beats = (vl_i >> log2(VLANE_NUM)) + (vl_i[log2(VLANE_NUM)-1:0] != 0).
  - Go to LOAD.
- State LOAD (exactly 1 cycle):
  - load_o=1; beat_cnt<=0; part_cnt<=0.
  - Next state:
    - beats != 0 -> STREAM.
    - beats == 0 and is_red -> PARTIAL.
    - otherwise -> DONE.
- State STREAM:
  - shift_en_o = out_ready_i (combinational, same cycle).
  - Each cycle with out_ready_i: beat_cnt++.
  - When beat_cnt == beats-1 and out_ready_i: go to PARTIAL if is_red, else DONE.
  - Stall (out_ready_i=0): hold all state; no shift.
- State PARTIAL:
  - shift_partial_o = out_ready_i; part_cnt++ on each transfer.
  - After VLANE_NUM-1 transfers: go to DONE.
- State DONE (1 cycle): done_o=1; then IDLE.
- busy_o=1 in every state except IDLE. start_ready_o=0 outside IDLE; descriptors presented then are not consumed.
- shift_en_o and shift_partial_o are never asserted in the same cycle; load_o never coincides with either.
- Widths:
  - beats and beat_cnt are $clog2(MAX_VL_PER_LANE)+1 bits, so a full-length vl cannot overflow.
  - part_cnt is $clog2(VLANE_NUM) bits.
- vl exactly a multiple of VLANE_NUM: beats = vl/VLANE_NUM; no extra all-invalid beat is issued.
- Back-to-back: a new descriptor is accepted at the earliest in the cycle after DONE (IDLE). Minimum spacing is beats+3 cycles without reduction.
- Reset mid-operation: aborts immediately to IDLE; no done_o pulse.

Decomposition:
- Shared package v_dpu_pkg:
  - seq_state_e enum (IDLE, LOAD, STREAM, PARTIAL, DONE).
  - Width localparams: VL_W, BEAT_W, PART_W.
- No sub-module is needed. Testbenches instantiate the block together with the existing lane valid-mask generator to check end-to-end valid patterns.

Test Plan:
- vl=20, reduction=0, out_ready=1 (VLANE_NUM=8) -> load 1 cycle, shift_en for 3 cycles, done one cycle later; start_valid accepted to done = 5 cycles.
- vl=16, reduction=0 -> exactly 2 shift_en beats, no third beat; done_o single pulse.
- vl=0, reduction=0 -> LOAD then DONE; shift_en_o and shift_partial_o never asserted.
- vl=5, reduction=1 -> 1 shift_en beat, then 7 shift_partial cycles, then done_o; never both shifts high together.
- vl=40, out_ready toggling 1,0,0,1,... -> shift_en_o only in cycles where out_ready=1; exactly 5 beats total; beat_cnt frozen during stalls.
- Assert rst_i asynchronously during STREAM beat 2 of 5 -> all outputs 0 and start_ready_o=1 immediately; no done_o; the next descriptor runs normally.

Source files
------------

// File: rtl/v_dpu_pkg.sv
// Shared types and width helpers for the vector DPU output-path sequencer.
package v_dpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STREAM  = 3'd2,
    PARTIAL = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  localparam int DEF_MAX_VL_PER_LANE = 256;
  localparam int DEF_VLANE_NUM       = 8;

  function automatic int calc_vl_w(input int lanes, input int max_vl_per_lane);
    return $clog2(lanes * max_vl_per_lane);
  endfunction

  // One extra bit so a full-length vector's beat count fits without wrapping.
  function automatic int calc_beat_w(input int max_vl_per_lane);
    return $clog2(max_vl_per_lane) + 1;
  endfunction

  function automatic int calc_part_w(input int lanes);
    return $clog2(lanes);
  endfunction

  localparam int VL_W   = calc_vl_w(DEF_VLANE_NUM, DEF_MAX_VL_PER_LANE);
  localparam int BEAT_W = calc_beat_w(DEF_MAX_VL_PER_LANE);
  localparam int PART_W = calc_part_w(DEF_VLANE_NUM);

endpackage

// File: rtl/v_dpu_seq_ctrl.sv
// Per-instruction sequencer: load pulse 1 cycle after accept, then ceil(vl/lanes) beats and optional lanes-1 partials.
// Transfers advance only while out_ready_i is high; start_ready_o is low for the whole instruction.
module v_dpu_seq_ctrl
  import v_dpu_pkg::*;
#(
  parameter int MAX_VL_PER_LANE = DEF_MAX_VL_PER_LANE,
  parameter int VLANE_NUM       = DEF_VLANE_NUM
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           start_valid_i,
  output logic                                           start_ready_o,
  input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]   vl_i,
  input  logic                                           reduction_i,
  input  logic                                           out_ready_i,
  output logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]   vl_o,
  output logic                                           load_o,
  output logic                                           shift_en_o,
  output logic                                           shift_partial_o,
  output logic                                           busy_o,
  output logic                                           done_o
);

  localparam int VL_WD     = calc_vl_w(VLANE_NUM, MAX_VL_PER_LANE);
  localparam int BEAT_WD   = calc_beat_w(MAX_VL_PER_LANE);
  localparam int PART_WD   = calc_part_w(VLANE_NUM);
  localparam int LANE_LOG2 = $clog2(VLANE_NUM);

  localparam logic [BEAT_WD-1:0] BEAT_ONE  = BEAT_WD'(1);
  localparam logic [PART_WD-1:0] PART_ONE  = PART_WD'(1);
  localparam logic [PART_WD-1:0] PART_LAST = PART_WD'(VLANE_NUM - 2);

  seq_state_e         state_q, state_d;
  logic [VL_WD-1:0]   vl_q, vl_d;
  logic               is_red_q, is_red_d;
  logic [BEAT_WD-1:0] beats_q, beats_d;
  logic [BEAT_WD-1:0] beat_cnt_q, beat_cnt_d;
  logic [PART_WD-1:0] part_cnt_q, part_cnt_d;
  logic [BEAT_WD-1:0] beats_calc;

  // Round up: any leftover elements in the low bits cost one more beat.
  assign beats_calc = BEAT_WD'(vl_i >> LANE_LOG2)
                    + BEAT_WD'(|vl_i[LANE_LOG2-1:0]);

  always_comb begin
    state_d         = state_q;
    vl_d            = vl_q;
    is_red_d        = is_red_q;
    beats_d         = beats_q;
    beat_cnt_d      = beat_cnt_q;
    part_cnt_d      = part_cnt_q;
    start_ready_o   = 1'b0;
    load_o          = 1'b0;
    shift_en_o      = 1'b0;
    shift_partial_o = 1'b0;
    done_o          = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          vl_d     = vl_i;
          is_red_d = reduction_i;
          beats_d  = beats_calc;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        load_o     = 1'b1;
        beat_cnt_d = '0;
        part_cnt_d = '0;
        if (beats_q != '0) begin
          state_d = STREAM;
        end else if (is_red_q) begin
          state_d = PARTIAL;
        end else begin
          state_d = DONE;
        end
      end

      STREAM: begin
        shift_en_o = out_ready_i;
        if (out_ready_i) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          if (beat_cnt_q == beats_q - BEAT_ONE) begin
            state_d = is_red_q ? PARTIAL : DONE;
          end
        end
      end

      PARTIAL: begin
        shift_partial_o = out_ready_i;
        if (out_ready_i) begin
          part_cnt_d = part_cnt_q + PART_ONE;
          if (part_cnt_q == PART_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vl_q       <= '0;
      is_red_q   <= 1'b0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      part_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vl_q       <= vl_d;
      is_red_q   <= is_red_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      part_cnt_q <= part_cnt_d;
    end
  end

  assign vl_o   = vl_q;
  assign busy_o = (state_q != IDLE);

endmodule
